// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the clk domain: master pins are oversampled,
// and one m-bit word is exchanged per LOAD-low frame, MSB first.
module spi_slave_sync #(
  parameter int m = 15
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         LOAD,
  input  logic         SCLK,
  input  logic         MOSI,
  output logic         MISO,
  input  logic [m-1:0] STX_DAT,
  input  logic         tx_we,
  output logic         tx_busy,
  output logic [m-1:0] SRX_DAT,
  output logic         rx_vld,
  output logic         frame_err,
  output logic [m-1:0] sr_STX,
  output logic [m-1:0] sr_SRX,
  output logic [7:0]   cb_bit
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [7:0] M_BITS  = 8'(m);
  localparam logic [7:0] CB_SAT  = 8'(m + 1);

  logic [2:0]   load_sync_q, load_sync_d;
  logic [2:0]   sclk_sync_q, sclk_sync_d;
  logic [1:0]   mosi_sync_q, mosi_sync_d;
  logic [0:0]   state_q, state_d;
  logic [m-1:0] tx_buf_q, tx_buf_d;
  logic [m-1:0] sr_stx_q, sr_stx_d;
  logic [m-1:0] sr_srx_q, sr_srx_d;
  logic [m-1:0] srx_dat_q, srx_dat_d;
  logic [7:0]   cb_bit_q, cb_bit_d;
  logic         miso_q, miso_d;
  logic         rx_vld_q, rx_vld_d;
  logic         frame_err_q, frame_err_d;

  logic load_rise, load_fall, sclk_rise, sclk_fall, mosi_bit;

  // Edges compare stage 2 against stage 3, so their effect lands on the third clk.
  assign load_rise = load_sync_q[1] & ~load_sync_q[2];
  assign load_fall = ~load_sync_q[1] & load_sync_q[2];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign mosi_bit  = mosi_sync_q[1];

  always_comb begin
    load_sync_d = {load_sync_q[1:0], LOAD};
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
    state_d     = state_q;
    tx_buf_d    = tx_we ? STX_DAT : tx_buf_q;
    sr_stx_d    = sr_stx_q;
    sr_srx_d    = sr_srx_q;
    srx_dat_d   = srx_dat_q;
    cb_bit_d    = cb_bit_q;
    miso_d      = miso_q;
    rx_vld_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        // tx_buf_d already carries a same-cycle write, giving the bypass.
        if (load_fall) begin
          sr_stx_d = tx_buf_d;
          miso_d   = tx_buf_d[m-1];
          cb_bit_d = 8'd0;
          sr_srx_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (load_rise) begin
          if (cb_bit_q == M_BITS) begin
            srx_dat_d = sr_srx_q;
            rx_vld_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_rise) begin
          sr_srx_d = {sr_srx_q[m-2:0], mosi_bit};
          if (cb_bit_q < CB_SAT) begin
            cb_bit_d = cb_bit_q + 8'd1;
          end
        end else if (sclk_fall && (cb_bit_q >= 8'd1) && (cb_bit_q < M_BITS)) begin
          sr_stx_d = {sr_stx_q[m-2:0], 1'b0};
          miso_d   = sr_stx_q[m-2];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      load_sync_q <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      tx_buf_q    <= '0;
      sr_stx_q    <= '0;
      sr_srx_q    <= '0;
      srx_dat_q   <= '0;
      cb_bit_q    <= '0;
      miso_q      <= 1'b0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      load_sync_q <= load_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      sr_stx_q    <= sr_stx_d;
      sr_srx_q    <= sr_srx_d;
      srx_dat_q   <= srx_dat_d;
      cb_bit_q    <= cb_bit_d;
      miso_q      <= miso_d;
      rx_vld_q    <= rx_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = miso_q;
  assign tx_busy   = (state_q == SHIFT);
  assign SRX_DAT   = srx_dat_q;
  assign rx_vld    = rx_vld_q;
  assign frame_err = frame_err_q;
  assign sr_STX    = sr_stx_q;
  assign sr_SRX    = sr_srx_q;
  assign cb_bit    = cb_bit_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a behavioural SPI master drives directed and random
// frames, and a word-level model predicts what each side should receive.
`timescale 1ns/1ps
module tb_spi_slave_sync;

  localparam int M = 15;

  logic         clk = 1'b0;
  logic         RESET, LOAD, SCLK, MOSI, tx_we;
  logic [M-1:0] STX_DAT;
  logic         MISO, tx_busy, rx_vld, frame_err;
  logic [M-1:0] SRX_DAT, sr_STX, sr_SRX;
  logic [7:0]   cb_bit;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int frame_no = 0;

  logic [M-1:0] tx_model;   // word the slave should transmit next frame
  logic [M-1:0] srx_model;  // last word the slave should have accepted

  spi_slave_sync #(.m(M)) dut (
    .clk(clk), .RESET(RESET), .LOAD(LOAD), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .STX_DAT(STX_DAT), .tx_we(tx_we), .tx_busy(tx_busy), .SRX_DAT(SRX_DAT),
    .rx_vld(rx_vld), .frame_err(frame_err), .sr_STX(sr_STX), .sr_SRX(sr_SRX),
    .cb_bit(cb_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Pulse monitor: counts strobes and checks they never coincide.
  always @(negedge clk) begin
    if (!RESET && (rx_vld || frame_err)) begin
      chk("vld_err_excl", 32'(rx_vld & frame_err), 32'd0);
      if (rx_vld) vld_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  function automatic logic mbit(input logic [M-1:0] w, input int i, input int n);
    if (i >= n) return 1'b0;
    if (i < M) return w[M-1-i];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({MISO, tx_busy, rx_vld, frame_err, cb_bit}), 32'd0);
    chk({tag, "_dat"}, 32'(SRX_DAT | sr_STX | sr_SRX), 32'd0);
  endtask

  // we_at: -1 none, -2 write in the same clk as the detected LOAD fall,
  // otherwise the bit index during whose SCLK-high phase tx_we is pulsed.
  // rst_at: bit index where RESET is pulsed, or -1.
  task automatic run_frame(input logic [M-1:0] mtx, input int nbits, input int we_at,
                           input logic [M-1:0] we_val, input int rst_at, input int gap);
    logic [M-1:0] sent, got_word;
    int v0, e0, k, exp_cb;
    bit aborted, exp_v, exp_e;
    aborted = 0;
    v0 = vld_cnt;
    e0 = err_cnt;
    sent = tx_model;
    got_word = '0;
    MOSI = mbit(mtx, 0, nbits);
    LOAD = 1'b0;
    if (we_at == -2) begin
      tick; tick;
      STX_DAT = we_val; tx_we = 1'b1;
      tick;
      tx_we = 1'b0;
      tick;
      sent = we_val;
      tx_model = we_val;
    end else begin
      repeat (4) tick;
    end
    chk("busy_start", 32'(tx_busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (!aborted) begin
        if (i < M) got_word[M-1-i] = MISO;
        else chk("miso_hold", 32'(MISO), 32'(sent[0]));
      end
      SCLK = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (j == 1 && i == we_at) begin
          STX_DAT = we_val; tx_we = 1'b1;
        end
        if (j == 2 && i == we_at) begin
          tx_we = 1'b0;
          tx_model = we_val;
        end
        if (j == 1 && i == rst_at) begin
          RESET = 1'b1;
          #1;
          chk_all_zero("midreset");
          aborted = 1;
          tx_model = '0;
          srx_model = '0;
        end
        if (j == 2 && i == rst_at) RESET = 1'b0;
        tick;
      end
      SCLK = 1'b0;
      MOSI = mbit(mtx, i + 1, nbits);
      repeat (4) tick;
    end
    exp_cb = (nbits > M + 1) ? M + 1 : nbits;
    if (!aborted) begin
      chk("cb_bit", 32'(cb_bit), 32'(exp_cb));
      if (nbits == M) chk("sr_SRX", 32'(sr_SRX), 32'(mtx));
    end
    LOAD = 1'b1;
    tick; tick;
    chk("lat_early", 32'({rx_vld, frame_err}), 32'd0);
    tick;
    exp_v = !aborted && (nbits == M);
    exp_e = !aborted && (nbits != M);
    chk("rx_vld", 32'(rx_vld), 32'(exp_v));
    chk("frame_err", 32'(frame_err), 32'(exp_e));
    tick;
    chk("pulse_end", 32'({rx_vld, frame_err}), 32'd0);
    chk("idle_busy_miso", 32'({tx_busy, MISO}), 32'd0);
    if (exp_v) srx_model = mtx;
    chk("SRX_DAT", 32'(SRX_DAT), 32'(srx_model));
    chk("vld_count", 32'(vld_cnt - v0), 32'(exp_v));
    chk("err_count", 32'(err_cnt - e0), 32'(exp_e));
    if (!aborted) begin
      k = (nbits > M) ? M : nbits;
      chk("master_rx", 32'(got_word >> (M - k)), 32'(sent >> (M - k)));
    end
    $display("frame %0d bits=%0d mosi=%h miso_word=%h sent=%h aborted=%0d",
             frame_no, nbits, mtx, got_word, sent, aborted);
    frame_no++;
    if (gap > 4) repeat (gap - 4) tick;
  endtask

  task automatic write_tx(input logic [M-1:0] v);
    STX_DAT = v; tx_we = 1'b1;
    tick;
    tx_we = 1'b0;
    tx_model = v;
  endtask

  initial begin
    int nb, sel, wa;
    logic [M-1:0] d, w;
    RESET = 1'b1; LOAD = 1'b1; SCLK = 1'b0; MOSI = 1'b0; tx_we = 1'b0; STX_DAT = '0;
    tx_model = '0;
    srx_model = '0;
    repeat (3) tick;
    chk_all_zero("reset");
    RESET = 1'b0;
    repeat (6) tick;
    chk_all_zero("post_reset");

    write_tx(15'h56AA);
    tick;
    run_frame(15'h7C33, M, -1, '0, -1, 6);           // nominal
    run_frame(M'($urandom), 8, -1, '0, -1, 6);       // short frame
    run_frame(M'($urandom), 17, -1, '0, -1, 6);      // overrun, cb saturates
    run_frame(M'($urandom), M, 5, 15'h1234, -1, 6);  // write mid-frame
    run_frame(M'($urandom), M, -1, '0, -1, 6);
    run_frame(M'($urandom), M, -1, '0, -1, 6);
    run_frame(M'($urandom), M, -1, '0, 7, 6);        // reset mid-frame
    run_frame(15'h0F0F, M, -1, '0, -1, 6);
    run_frame(15'h7FFF, M, -1, '0, -1, 4);           // back-to-back
    run_frame(15'h0001, M, -1, '0, -1, 6);
    run_frame(M'($urandom), M, -2, 15'h2D5B, -1, 6); // same-clk write bypass

    for (int r = 0; r < 40; r++) begin
      d = M'($urandom);
      w = M'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, M + 2)) : M;
      sel = int'($urandom_range(0, 3));
      wa = (sel == 0) ? -2 : (sel == 1) ? int'($urandom_range(0, nb - 1)) : -1;
      if ($urandom_range(0, 3) == 0) begin
        write_tx(M'($urandom));
        tick;
      end
      run_frame(d, nb, wa, w, -1, int'($urandom_range(4, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
